// File: rtl/data_bus_bridge.sv
// CPU data-port bridge: routes each access to data_ram or to a small MMIO register file,
// maps kseg0/kseg1 to physical addresses. Optional timer enabled by DATA_BUS_BRIDGE_TIMER_EN.
module data_bus_bridge #(
    parameter logic [15:0] MMIO_BASE_HI = 16'hBFAF,
    parameter int          LED_W        = 16,
    parameter int          SW_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_en,
    input  logic [3:0]       cpu_wen,
    input  logic [31:0]      cpu_addr,
    input  logic [31:0]      cpu_wdata,
    output logic [31:0]      cpu_rdata,
    output logic             ram_en,
    output logic [3:0]       ram_wen,
    output logic [31:0]      ram_addr,
    output logic [31:0]      ram_wdata,
    input  logic [31:0]      ram_rdata,
    input  logic [SW_W-1:0]  sw_in,
    output logic [LED_W-1:0] led_out,
    output logic             timer_irq
);

    localparam logic [13:0] OFF_LED     = 14'd0;
    localparam logic [13:0] OFF_SWITCH  = 14'd1;
    localparam logic [13:0] OFF_TIMER   = 14'd2;
    localparam logic [13:0] OFF_CMP     = 14'd3;
    localparam logic [13:0] OFF_SCRATCH = 14'd4;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
        logic [31:0] r;
        r = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_val[8*b +: 8];
        end
        return r;
    endfunction

    logic              is_mmio;
    logic              mmio_wr;
    logic [13:0]       word_off;
    logic [LED_W-1:0]  led_q;
    logic [LED_W-1:0]  led_d;
    logic [31:0]       scratch_q;
    logic [SW_W-1:0]   sw_s1;
    logic [SW_W-1:0]   sw_s2;
    logic              sel_mmio_q;
    logic [31:0]       mmio_rdata_q;
    logic [31:0]       mmio_rdata_d;
    logic [31:0]       timer_rd;
    logic [31:0]       cmp_rd;

    assign is_mmio  = cpu_en && (cpu_addr[31:16] == MMIO_BASE_HI);
    assign word_off = cpu_addr[15:2];
    assign mmio_wr  = is_mmio && (|cpu_wen);

    assign ram_en    = cpu_en & ~is_mmio;
    assign ram_wen   = ram_en ? cpu_wen : 4'b0000;
    assign ram_wdata = cpu_wdata;
    assign ram_addr  = (cpu_addr[31:30] == 2'b10) ? {3'b000, cpu_addr[28:0]} : cpu_addr;

    always_comb begin
        led_d = led_q;
        for (int i = 0; i < LED_W; i++) begin
            if (cpu_wen[i/8]) led_d[i] = cpu_wdata[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q     <= '0;
            scratch_q <= '0;
        end else begin
            if (mmio_wr && word_off == OFF_LED)     led_q     <= led_d;
            if (mmio_wr && word_off == OFF_SCRATCH) scratch_q <= byte_merge(scratch_q, cpu_wdata, cpu_wen);
        end
    end

    // Switches are asynchronous to clk, so they cross through two flops before being read.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
        end else begin
            sw_s1 <= sw_in;
            sw_s2 <= sw_s1;
        end
    end

`ifdef DATA_BUS_BRIDGE_TIMER_EN
    logic [31:0] timer_q;
    logic [31:0] cmp_q;
    logic        irq_q;
    logic        wr_timer;
    logic        wr_cmp;

    assign wr_timer = mmio_wr && word_off == OFF_TIMER;
    assign wr_cmp   = mmio_wr && word_off == OFF_CMP;

    // A compare write clears the sticky interrupt even when it lands on a match cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
            cmp_q   <= 32'hFFFF_FFFF;
            irq_q   <= 1'b0;
        end else begin
            if (wr_timer) timer_q <= byte_merge(timer_q, cpu_wdata, cpu_wen);
            else          timer_q <= timer_q + 32'd1;
            if (wr_cmp)   cmp_q   <= byte_merge(cmp_q, cpu_wdata, cpu_wen);
            if (wr_cmp)                  irq_q <= 1'b0;
            else if (timer_q == cmp_q)   irq_q <= 1'b1;
        end
    end

    assign timer_rd  = timer_q;
    assign cmp_rd    = cmp_q;
    assign timer_irq = irq_q;
`else
    assign timer_rd  = '0;
    assign cmp_rd    = '0;
    assign timer_irq = 1'b0;
`endif

    always_comb begin
        mmio_rdata_d = '0;
        case (word_off)
            OFF_LED:     mmio_rdata_d = 32'(led_q);
            OFF_SWITCH:  mmio_rdata_d = 32'(sw_s2);
            OFF_TIMER:   mmio_rdata_d = timer_rd;
            OFF_CMP:     mmio_rdata_d = cmp_rd;
            OFF_SCRATCH: mmio_rdata_d = scratch_q;
            default:     mmio_rdata_d = '0;
        endcase
    end

    // Registering the MMIO value alongside the select matches the block RAM's one-cycle read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_mmio_q   <= 1'b0;
            mmio_rdata_q <= '0;
        end else if (cpu_en) begin
            sel_mmio_q   <= is_mmio;
            mmio_rdata_q <= mmio_rdata_d;
        end
    end

    assign cpu_rdata = sel_mmio_q ? mmio_rdata_q : ram_rdata;
    assign led_out   = led_q;

endmodule
